fft_butterfly_stage: RTL and testbench

FFT_BUTTERFLY_STAGE -- requirements
Module: fft_butterfly_stage

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_cmul.sv | 45 ++++
 rtl/fft_butterfly_stage.sv | 141 ++++++++++++++
 tb/tb_fft_butterfly_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and twiddle-address helper for the radix-2 8-point FFT butterfly stage.
package fft_pkg;
  localparam int DATA_W       = 16;
  localparam int TW_W         = 8;
  localparam int TW_FRAC      = 7;
  localparam int FFT_N        = 8;
  localparam int N_STAGES     = 3;
  localparam int BF_PER_STAGE = FFT_N / 2;

  typedef logic [1:0] stage_t;
  typedef logic [1:0] bf_cnt_t;

  localparam stage_t  LAST_STAGE = stage_t'(N_STAGES - 1);
  localparam bf_cnt_t LAST_BF    = bf_cnt_t'(BF_PER_STAGE - 1);

  // Twiddle index = (j mod 2^stage) << (2 - stage), within a quarter-circle table.
  function automatic logic [2:0] tw_addr_f(input stage_t stg, input bf_cnt_t j);
    logic [2:0] addr;
    case (stg)
      2'd0:    addr = 3'd0;
      2'd1:    addr = {1'b0, j[0], 1'b0};
      2'd2:    addr = {1'b0, j};
      default: addr = 3'd0;
    endcase
    return addr;
  endfunction
endpackage

// File: rtl/fft_cmul.sv
// Combinational complex multiply b*w with Q1.7 twiddle, round-half-up and saturation to DATA_W.
module fft_cmul #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int TW_W   = fft_pkg::TW_W
) (
  input  logic signed [DATA_W-1:0] b_re_i,
  input  logic signed [DATA_W-1:0] b_im_i,
  input  logic signed [TW_W-1:0]   w_re_i,
  input  logic signed [TW_W-1:0]   w_im_i,
  output logic signed [DATA_W-1:0] t_re_o,
  output logic signed [DATA_W-1:0] t_im_o
);
  import fft_pkg::*;

  localparam int PROD_W = DATA_W + TW_W;
  localparam int ACC_W  = PROD_W + 1;
  localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (TW_FRAC - 1);

  // Clamp when the bits above the result sign are not a pure sign extension.
  function automatic logic signed [DATA_W-1:0] sat_f(input logic signed [ACC_W-1:0] x);
    logic signed [DATA_W-1:0] r;
    if ((&x[ACC_W-1:DATA_W-1]) || !(|x[ACC_W-1:DATA_W-1])) begin
      r = x[DATA_W-1:0];
    end else if (x[ACC_W-1]) begin
      r = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end
    return r;
  endfunction

  logic signed [PROD_W-1:0] p_rr_s, p_ii_s, p_ri_s, p_ir_s;
  logic signed [ACC_W-1:0]  acc_re_s, acc_im_s, shr_re_s, shr_im_s;

  assign p_rr_s   = PROD_W'(b_re_i) * PROD_W'(w_re_i);
  assign p_ii_s   = PROD_W'(b_im_i) * PROD_W'(w_im_i);
  assign p_ri_s   = PROD_W'(b_re_i) * PROD_W'(w_im_i);
  assign p_ir_s   = PROD_W'(b_im_i) * PROD_W'(w_re_i);
  assign acc_re_s = ACC_W'(p_rr_s) - ACC_W'(p_ii_s) + RND;
  assign acc_im_s = ACC_W'(p_ri_s) + ACC_W'(p_ir_s) + RND;
  assign shr_re_s = acc_re_s >>> TW_FRAC;
  assign shr_im_s = acc_im_s >>> TW_FRAC;
  assign t_re_o   = sat_f(shr_re_s);
  assign t_im_o   = sat_f(shr_im_s);
endmodule

// File: rtl/fft_butterfly_stage.sv
// Pipelined radix-2 DIT butterfly (capture, complex multiply, add/sub) with stage/twiddle
// sequencing for an 8-point frame and a single global stall enable.
module fft_butterfly_stage #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int TW_W   = fft_pkg::TW_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [2:0]               tw_addr,
  input  logic [2*TW_W-1:0]        twiddle,
  output logic signed [DATA_W-1:0] y0_re,
  output logic signed [DATA_W-1:0] y0_im,
  output logic signed [DATA_W-1:0] y1_re,
  output logic signed [DATA_W-1:0] y1_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               stage,
  output logic                     frame_done
);
  import fft_pkg::*;

  logic    en_s, acc_s;
  bf_cnt_t bf_cnt_q, bf_cnt_d;
  stage_t  stage_q, stage_d;
  logic    frame_done_q, frame_done_d;
  logic    v1_q, v2_q, out_valid_q;

  logic signed [DATA_W-1:0] a1_re_q, a1_im_q, b1_re_q, b1_im_q;
  logic signed [TW_W-1:0]   w1_re_q, w1_im_q;
  logic signed [DATA_W-1:0] a2_re_q, a2_im_q, t2_re_q, t2_im_q;
  logic signed [DATA_W-1:0] t_re_s, t_im_s;
  logic signed [DATA_W:0]   s0_re_s, s0_im_s, s1_re_s, s1_im_s;
  logic signed [DATA_W-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
  logic signed [DATA_W-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;

  fft_cmul #(.DATA_W(DATA_W), .TW_W(TW_W)) u_cmul (
    .b_re_i (b1_re_q),
    .b_im_i (b1_im_q),
    .w_re_i (w1_re_q),
    .w_im_i (w1_im_q),
    .t_re_o (t_re_s),
    .t_im_o (t_im_s)
  );

  // Handshake, frame sequencing and the halving add/sub stage.
  always_comb begin
    en_s         = !out_valid_q || out_ready;
    acc_s        = in_valid && en_s && !rst;
    bf_cnt_d     = bf_cnt_q;
    stage_d      = stage_q;
    frame_done_d = 1'b0;
    if (acc_s) begin
      bf_cnt_d = bf_cnt_q + 2'd1;
      if (bf_cnt_q == LAST_BF) begin
        if (stage_q == LAST_STAGE) begin
          stage_d      = 2'd0;
          frame_done_d = 1'b1;
        end else begin
          stage_d = stage_q + 2'd1;
        end
      end else begin
        stage_d = stage_q;
      end
    end else begin
      bf_cnt_d = bf_cnt_q;
    end
    s0_re_s = {a2_re_q[DATA_W-1], a2_re_q} + {t2_re_q[DATA_W-1], t2_re_q};
    s0_im_s = {a2_im_q[DATA_W-1], a2_im_q} + {t2_im_q[DATA_W-1], t2_im_q};
    s1_re_s = {a2_re_q[DATA_W-1], a2_re_q} - {t2_re_q[DATA_W-1], t2_re_q};
    s1_im_s = {a2_im_q[DATA_W-1], a2_im_q} - {t2_im_q[DATA_W-1], t2_im_q};
    y0_re_d = s0_re_s[DATA_W:1];
    y0_im_d = s0_im_s[DATA_W:1];
    y1_re_d = s1_re_s[DATA_W:1];
    y1_im_d = s1_im_s[DATA_W:1];
  end

  // Counters advance per accepted butterfly; the whole pipeline moves only when en_s is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_cnt_q     <= 2'd0;
      stage_q      <= 2'd0;
      frame_done_q <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      a1_re_q      <= '0;
      a1_im_q      <= '0;
      b1_re_q      <= '0;
      b1_im_q      <= '0;
      w1_re_q      <= '0;
      w1_im_q      <= '0;
      a2_re_q      <= '0;
      a2_im_q      <= '0;
      t2_re_q      <= '0;
      t2_im_q      <= '0;
      y0_re_q      <= '0;
      y0_im_q      <= '0;
      y1_re_q      <= '0;
      y1_im_q      <= '0;
    end else begin
      bf_cnt_q     <= bf_cnt_d;
      stage_q      <= stage_d;
      frame_done_q <= frame_done_d;
      if (en_s) begin
        v1_q        <= acc_s;
        a1_re_q     <= a_re;
        a1_im_q     <= a_im;
        b1_re_q     <= b_re;
        b1_im_q     <= b_im;
        w1_re_q     <= twiddle[2*TW_W-1:TW_W];
        w1_im_q     <= twiddle[TW_W-1:0];
        v2_q        <= v1_q;
        a2_re_q     <= a1_re_q;
        a2_im_q     <= a1_im_q;
        t2_re_q     <= t_re_s;
        t2_im_q     <= t_im_s;
        out_valid_q <= v2_q;
        y0_re_q     <= y0_re_d;
        y0_im_q     <= y0_im_d;
        y1_re_q     <= y1_re_d;
        y1_im_q     <= y1_im_d;
      end
    end
  end

  assign in_ready   = en_s;
  assign tw_addr    = tw_addr_f(stage_q, bf_cnt_q);
  assign stage      = stage_q;
  assign frame_done = frame_done_q;
  assign out_valid  = out_valid_q;
  assign y0_re      = y0_re_q;
  assign y0_im      = y0_im_q;
  assign y1_re      = y1_re_q;
  assign y1_im      = y1_im_q;
endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Randomized bench for fft_butterfly_stage: arithmetic reference model plus scoreboard queue.
module tb_fft_butterfly_stage;
  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic in_valid, in_ready;
  logic [2:0] tw_addr;
  logic [15:0] twiddle;
  logic signed [15:0] y0_re, y0_im, y1_re, y1_im;
  logic out_valid, out_ready;
  logic [1:0] stage;
  logic frame_done;

  int total = 0;
  int bad = 0;
  logic use_tbl, rand_rdy, rdy_force, log_on;
  logic [15:0] tw_fixed;
  logic [15:0] tbl [8];
  int n_acc = 0;
  int fd_cnt = 0;
  longint en_cnt = 0;
  bit exp_fd = 1'b0;
  bit hold_v = 1'b0;
  logic signed [15:0] hold_y [4];
  int addr_log[$];
  bit bp_done;

  typedef struct { int y0r; int y0i; int y1r; int y1i; longint en; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  fft_butterfly_stage dut (
    .clk(clk), .rst(rst),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .in_valid(in_valid), .in_ready(in_ready),
    .tw_addr(tw_addr), .twiddle(twiddle),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .stage(stage), .frame_done(frame_done)
  );

  always_comb twiddle = use_tbl ? tbl[tw_addr] : tw_fixed;

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : rdy_force;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int sat16(input int x);
    return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
  endfunction

  function automatic void model(input int ar, input int ai, input int br, input int bi,
                                input logic [15:0] tw,
                                output int y0r, output int y0i, output int y1r, output int y1i);
    int wr, wi, tr, ti;
    wr  = int'($signed(tw[15:8]));
    wi  = int'($signed(tw[7:0]));
    tr  = sat16((br * wr - bi * wi + 64) >>> 7);
    ti  = sat16((br * wi + bi * wr + 64) >>> 7);
    y0r = (ar + tr) >>> 1;
    y0i = (ai + ti) >>> 1;
    y1r = (ar - tr) >>> 1;
    y1i = (ai - ti) >>> 1;
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    int pick;
    pick = int'($urandom_range(0, 5));
    r = 16'($urandom);
    case (pick)
      0: return 32767;
      1: return -32768;
      default: return int'($signed(r));
    endcase
  endfunction

  // Scoreboard: one compare pass per falling edge against the queued model results.
  int m_n, m_st, m_j, m_ea;
  exp_t m_e;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      n_acc  = 0;
      exp_fd = 1'b0;
      hold_v = 1'b0;
    end else begin
      chk(frame_done == exp_fd, "frame_done", longint'(frame_done), longint'(exp_fd));
      if (frame_done) fd_cnt++;
      chk(int'(stage) == (n_acc % 12) / 4, "stage", longint'(stage), longint'((n_acc % 12) / 4));
      chk(in_ready == (!out_valid || out_ready), "in_ready", longint'(in_ready),
          longint'(!out_valid || out_ready));
      if (hold_v) begin
        chk(out_valid && y0_re == hold_y[0] && y0_im == hold_y[1] && y1_re == hold_y[2]
            && y1_im == hold_y[3], "hold_stable", longint'(y0_re), longint'(hold_y[0]));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk(1'b0, "spurious_out", 1, 0);
        end else begin
          chk(en_cnt - q[0].en == 64'sd3, "latency", en_cnt - q[0].en, 3);
          chk(int'(y0_re) == q[0].y0r, "y0_re", longint'(y0_re), longint'(q[0].y0r));
          chk(int'(y0_im) == q[0].y0i, "y0_im", longint'(y0_im), longint'(q[0].y0i));
          chk(int'(y1_re) == q[0].y1r, "y1_re", longint'(y1_re), longint'(q[0].y1r));
          chk(int'(y1_im) == q[0].y1i, "y1_im", longint'(y1_im), longint'(q[0].y1i));
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0 && en_cnt - q[0].en >= 64'sd3) begin
        chk(1'b0, "missing_out", 0, 1);
      end
      hold_v    = out_valid && !out_ready;
      hold_y[0] = y0_re;
      hold_y[1] = y0_im;
      hold_y[2] = y1_re;
      hold_y[3] = y1_im;
      exp_fd    = 1'b0;
      if (in_valid && in_ready) begin
        m_n  = n_acc % 12;
        m_st = m_n / 4;
        m_j  = m_n % 4;
        m_ea = (m_j % (1 << m_st)) << (2 - m_st);
        chk(int'(tw_addr) == m_ea, "tw_addr", longint'(tw_addr), longint'(m_ea));
        if (log_on) addr_log.push_back(int'(tw_addr));
        model(int'(a_re), int'(a_im), int'(b_re), int'(b_im), twiddle,
              m_e.y0r, m_e.y0i, m_e.y1r, m_e.y1i);
        m_e.en = en_cnt;
        q.push_back(m_e);
        exp_fd = (m_n == 11);
        n_acc++;
      end
      if (in_ready) en_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi);
    bit ok;
    ok = 1'b0;
    a_re = 16'(ar);
    a_im = 16'(ai);
    b_re = 16'(br);
    b_im = 16'(bi);
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk(1'b0, "send_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int y0r, y0i, y1r, y1i, acc0, fd0, gap;
    int exp_addr [12];
    exp_addr = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    rst = 1'b1; in_valid = 1'b0; use_tbl = 1'b0; rand_rdy = 1'b0; rdy_force = 1'b1;
    log_on = 1'b0; tw_fixed = 16'h0000; bp_done = 1'b0;
    a_re = 16'sd0; a_im = 16'sd0; b_re = 16'sd0; b_im = 16'sd0;
    for (int i = 0; i < 8; i++) tbl[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
    chk(y0_re == 16'sd0 && y0_im == 16'sd0 && y1_re == 16'sd0 && y1_im == 16'sd0,
        "rst_data", longint'(y0_re), 0);
    chk(frame_done == 1'b0, "rst_frame_done", longint'(frame_done), 0);
    chk(stage == 2'd0, "rst_stage", longint'(stage), 0);
    chk(tw_addr == 3'd0, "rst_tw_addr", longint'(tw_addr), 0);

    // Hand-computed pins of the reference model.
    model(100, 0, 50, 0, 16'h7F00, y0r, y0i, y1r, y1i);
    chk(y0r == 75 && y0i == 0 && y1r == 25 && y1i == 0, "model_unity", y0r, 75);
    model(0, 0, 64, 0, 16'h0080, y0r, y0i, y1r, y1i);
    chk(y0r == 0 && y0i == -32 && y1r == 0 && y1i == 32, "model_negj", y0i, -32);
    model(0, 0, 32767, 32767, 16'h8080, y0r, y0i, y1r, y1i);
    chk(y0r == 0 && y0i == -16384 && y1r == 0 && y1i == 16384, "model_sat", y0i, -16384);

    // Directed data-path vectors with a fixed twiddle.
    @(posedge clk); #1;
    tw_fixed = 16'h7F00; send(100, 0, 50, 0);
    tw_fixed = 16'h0080; send(0, 0, 64, 0);
    tw_fixed = 16'h8080; send(0, 0, 32767, 32767);
    cycles(6);

    // Twiddle addressing over one full frame.
    pulse_reset();
    use_tbl = 1'b1;
    fd0 = fd_cnt;
    log_on = 1'b1;
    for (int i = 0; i < 12; i++) send(rnd16(), rnd16(), rnd16(), rnd16());
    log_on = 1'b0;
    cycles(5);
    @(negedge clk);
    chk(addr_log.size() == 12, "addr_log_len", addr_log.size(), 12);
    for (int i = 0; i < 12 && i < addr_log.size(); i++)
      chk(addr_log[i] == exp_addr[i], "addr_seq", addr_log[i], exp_addr[i]);
    chk(fd_cnt - fd0 == 1, "frame_done_count", fd_cnt - fd0, 1);
    chk(stage == 2'd0, "stage_wrap", longint'(stage), 0);

    // Backpressure: only three items fit while the output is stalled.
    @(posedge clk); #1;
    pulse_reset();
    rdy_force = 1'b0;
    cycles(2);
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 5; i++) send(1000 * i + 1, -i, 300 * i, 77);
        bp_done = 1'b1;
      end
    join_none
    cycles(10);
    @(negedge clk);
    chk(n_acc - acc0 == 3, "bp_accepted", n_acc - acc0, 3);
    chk(in_ready == 1'b0, "bp_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    rdy_force = 1'b1;
    for (int k = 0; k < 100 && !bp_done; k++) cycles(1);
    chk(bp_done, "bp_release", longint'(bp_done), 1);
    cycles(6);
    @(negedge clk);
    chk(n_acc - acc0 == 5, "bp_total", n_acc - acc0, 5);
    chk(q.size() == 0, "bp_drain", q.size(), 0);

    // Reset with two items in flight.
    @(posedge clk); #1;
    send(1234, -55, 999, 3);
    send(-700, 42, 12000, -9000);
    pulse_reset();
    @(negedge clk);
    chk(out_valid == 1'b0, "midrst_out_valid", longint'(out_valid), 0);
    chk(stage == 2'd0, "midrst_stage", longint'(stage), 0);
    chk(tw_addr == 3'd0, "midrst_tw_addr", longint'(tw_addr), 0);
    @(posedge clk); #1;
    cycles(8);

    // Randomized traffic with random output stalls and a random twiddle table.
    tbl[7] = 16'h8080;
    tbl[6] = 16'h7F7F;
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (gap > 0) cycles(gap);
      send(rnd16(), rnd16(), rnd16(), rnd16());
      if (i % 100 == 99) for (int t = 0; t < 8; t++) tbl[t] = 16'($urandom);
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    cycles(10);
    @(negedge clk);
    chk(q.size() == 0, "final_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
